// File: rtl/fifo_rx_pkg.sv
// fifo_rx_pkg: shared types and constants for the receive-side byte FIFO.
package fifo_rx_pkg;

  localparam int unsigned BYTE_BITS = 8;

  // Byte assembly states
  typedef enum logic {
    IDLE,
    SHIFT
  } fsm_rx;

  // Index of the next bit position within the byte being assembled
  typedef logic [2:0] bit_idx_t;

endpackage

// File: rtl/fifo_rx_if.sv
// fifo_rx_if: APB read-slave signal bundle for fifo_rx.
interface fifo_rx_if;
  import fifo_rx_pkg::*;

  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [BYTE_BITS-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/fifo_rx_sipo.sv
// fifo_rx_sipo: serial-in parallel-out byte assembler, LSB first.
// byte_done is a combinational pulse in the cycle the 8th bit is presented,
// with parallel_out already holding the complete byte.
module fifo_rx_sipo
  import fifo_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic                 serial_in,
  output logic [BYTE_BITS-1:0] parallel_out,
  output logic                 byte_done
);

  bit_idx_t             bit_cnt;
  logic [BYTE_BITS-1:0] shreg;
  logic [BYTE_BITS-1:0] byte_nxt;

  // Merge the incoming bit into its position to form the candidate byte
  always_comb begin
    byte_nxt          = shreg;
    byte_nxt[bit_cnt] = serial_in;
  end

  assign parallel_out = byte_nxt;
  assign byte_done    = shift_en && (bit_cnt == 3'd7);

  // Bit counter and shift register; clear discards a partial byte
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (shift_en) begin
      shreg   <= byte_nxt;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/fifo_rx.sv
// fifo_rx: receive-side byte FIFO. Assembles the demodulated bit stream into
// bytes, buffers them in a DEPTH-entry FIFO and serves them over a
// zero-wait-state APB read slave.
// Optional: define FIFO_RX_LEVEL_EN to add the registered `level` output.
module fifo_rx
  import fifo_rx_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           data_in,
  input  logic           bit_valid,
  input  logic           en_rx,
  fifo_rx_if.slave       apb,
  output logic           mem_state,
  output logic           overflow
`ifdef FIFO_RX_LEVEL_EN
  ,
  output logic [PTR_WIDTH:0] level
`endif
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0] wr_ptr_nxt, rd_ptr_nxt;
  fsm_rx              state, state_nxt;

  logic                 full, empty;
  logic                 rd_access, wr_access;
  logic                 pop, push_req, push_ok;
  logic                 clear, shift_en;
  logic [BYTE_BITS-1:0] rx_byte;

  fifo_rx_sipo u_sipo (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .shift_en     (shift_en),
    .serial_in    (data_in),
    .parallel_out (rx_byte),
    .byte_done    (push_req)
  );

  assign full  = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                 (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);
  assign empty = (wr_ptr == rd_ptr);
  assign mem_state = !empty;

  assign rd_access = apb.psel && apb.penable && !apb.pwrite;
  assign wr_access = apb.psel && apb.penable && apb.pwrite;
  assign pop       = rd_access && !empty;
  // A pop in the same cycle frees the slot the push lands in
  assign push_ok   = push_req && (!full || pop);

  // APB read data and error response
  always_comb begin
    apb.prdata  = '0;
    apb.pready  = 1'b1;
    apb.pslverr = wr_access || (rd_access && empty);
    if (pop) apb.prdata = mem[rd_ptr[PTR_WIDTH-1:0]];
  end

  // Assembly FSM next state; assembly runs only while SHIFT and en_rx hold
  always_comb begin
    state_nxt = state;
    clear     = 1'b1;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (en_rx) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (!en_rx) begin
          state_nxt = IDLE;
        end else begin
          clear    = 1'b0;
          shift_en = bit_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Assembly FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pointer advance
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (push_ok) wr_ptr_nxt = wr_ptr + 1'b1;
    if (pop)     rd_ptr_nxt = rd_ptr + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // FIFO storage write (contents not reset)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_WIDTH-1:0]] <= rx_byte;
  end

  // Sticky overflow: a dropped byte sets it, a successful read clears it
  always_ff @(posedge clk) begin
    if (reset)                      overflow <= 1'b0;
    else if (push_req && !push_ok)  overflow <= 1'b1;
    else if (pop)                   overflow <= 1'b0;
  end

`ifdef FIFO_RX_LEVEL_EN
  // Occupancy, registered alongside the pointers
  always_ff @(posedge clk) begin
    if (reset) level <= '0;
    else       level <= wr_ptr_nxt - rd_ptr_nxt;
  end
`endif

endmodule

// File: tb/tb_fifo_rx.sv
// tb_fifo_rx: directed and randomized checks of fifo_rx against a queue model.
module tb_fifo_rx;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset, data_in, bit_valid, en_rx;
  logic mem_state, overflow;
`ifdef FIFO_RX_LEVEL_EN
  logic [6:0] level;
`endif

  fifo_rx_if bus ();

  always #10 clk = ~clk;

  fifo_rx #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .bit_valid (bit_valid),
    .en_rx     (en_rx),
    .apb       (bus),
    .mem_state (mem_state),
    .overflow  (overflow)
`ifdef FIFO_RX_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: buffered bytes in arrival order plus the sticky flag
  logic [7:0] q[$];
  bit         ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ":mem_state"}, 32'(mem_state), 32'(q.size() != 0));
    chk({tag, ":overflow"}, 32'(overflow), 32'(ovf));
`ifdef FIFO_RX_LEVEL_EN
    chk({tag, ":level"}, 32'(level), 32'(q.size()));
`endif
  endtask

  // One clock edge of the model: pop first, then push into freed space
  task automatic model_edge(input bit push, input logic [7:0] b, input bit pop);
    bit pop_eff;
    bit accept;
    pop_eff = pop && (q.size() > 0);
    accept  = push && ((q.size() < DEPTH) || pop_eff);
    if (pop_eff) void'(q.pop_front());
    if (accept) q.push_back(b);
    if (push && !accept) ovf = 1'b1;
    else if (pop_eff)    ovf = 1'b0;
  endtask

  task automatic strobe(input bit b, input bit last, input logic [7:0] val, input int gap);
    repeat (gap) @(negedge clk);
    data_in   = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    data_in   = 1'($urandom);
    if (last) model_edge(1'b1, val, 1'b0);
    check_status("bit");
  endtask

  task automatic send_byte(input logic [7:0] val, input int gap);
    for (int i = 0; i < 8; i++) strobe(val[i], i == 7, val, gap);
  endtask

  task automatic start_rx;
    en_rx = 1'b1;
    @(negedge clk);
  endtask

  task automatic apb_read(input string tag);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b0;
    bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    #1;
    if (q.size() > 0) begin
      chk({tag, ":prdata"}, 32'(bus.prdata), 32'(q[0]));
      chk({tag, ":pslverr"}, 32'(bus.pslverr), 32'd0);
    end else begin
      chk({tag, ":prdata"}, 32'(bus.prdata), 32'd0);
      chk({tag, ":pslverr"}, 32'(bus.pslverr), 32'd1);
    end
    chk({tag, ":pready"}, 32'(bus.pready), 32'd1);
    @(negedge clk);
    model_edge(1'b0, 8'h00, 1'b1);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    #1;
    check_status(tag);
  endtask

  task automatic apb_write(input string tag);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b1;
    bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    #1;
    chk({tag, ":pslverr"}, 32'(bus.pslverr), 32'd1);
    chk({tag, ":prdata"}, 32'(bus.prdata), 32'd0);
    @(negedge clk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    #1;
    check_status(tag);
  endtask

  initial begin
    logic [7:0] b77;
    reset       = 1'b1;
    en_rx       = 1'b0;
    bit_valid   = 1'b0;
    data_in     = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    ovf         = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_status("reset");
    chk("reset:prdata", 32'(bus.prdata), 32'd0);
    chk("reset:pslverr", 32'(bus.pslverr), 32'd0);
    chk("reset:pready", 32'(bus.pready), 32'd1);

    // Single byte at 25 clocks per bit
    start_rx();
    send_byte(8'hA5, 24);
    apb_read("t1_read");

    // Empty read and write are errors and leave the FIFO alone
    apb_read("t2_empty");
    apb_write("t2_write");
    send_byte(8'h5C, 1);
    apb_read("t2_after");
    apb_read("t2_empty2");

    // Fill, overflow by one, then drain in order
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1);
    send_byte(8'h40, 1);
    check_status("t3_full");
    for (int i = 0; i <= DEPTH; i++) apb_read("t3_drain");

    // Aborted partial byte, and a strobe on the en_rx rising cycle is ignored
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 8'hFF, 1);
    en_rx = 1'b0;
    repeat (3) @(negedge clk);
    en_rx     = 1'b1;
    data_in   = 1'b1;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    send_byte(8'h12, 1);
    apb_read("t4_read");
    apb_read("t4_empty");

    // Push on the same edge as a pop while full
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 0);
    b77 = 8'h77;
    for (int i = 0; i < 7; i++) strobe(b77[i], 1'b0, b77, 1);
    @(negedge clk);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b0;
    bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    data_in     = b77[7];
    bit_valid   = 1'b1;
    #1;
    chk("t5:prdata", 32'(bus.prdata), 32'(q[0]));
    chk("t5:pslverr", 32'(bus.pslverr), 32'd0);
    @(negedge clk);
    model_edge(1'b1, b77, 1'b1);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bit_valid   = 1'b0;
    #1;
    check_status("t5_after");
    chk("t5:occupancy", 32'(q.size()), 32'(DEPTH));
    for (int i = 0; i <= DEPTH; i++) apb_read("t5_drain");

    // Randomized traffic, including possible overflow
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) != 0) send_byte(8'($urandom), int'($urandom_range(0, 2)));
      else apb_read("rnd_read");
    end
    while (q.size() > 0) apb_read("rnd_drain");

    // Reset mid-byte with data buffered
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1);
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 8'h00, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    ovf = 1'b0;
    #1;
    check_status("t6_reset");
    apb_read("t6_empty");
    start_rx();
    send_byte(8'h5A, 1);
    apb_read("t6_read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
